verinject_injection_scheduler: RTL and testbench
================================================

Name: verinject_injection_scheduler

Overview:
- Upstream driver of the 32-bit `verinject__injector_state` bus consumed by the memory/register injectors.
- A host or testbench queues timed injection commands as (target cycle, global bit index) pairs.
- The block counts run cycles and, when a command is due, drives its bit index onto the bus for exactly one cycle.
- Otherwise the bus holds the idle code 0xFFFF_FFFF, or the FIFO-reset code 0xFFFF_FFFE when a clear is requested.

Parameters:
- DEPTH, 4, number of command FIFO entries (power of two, ≥2).
- DEPTH_LOG2, 2, log2(DEPTH).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at the clock edge.
- cmd_cycle  in  32  target cycle_count value for the injection.
- cmd_index  in  32  global bit index to inject.
- run  in  1  cycle counter and scheduler enable.
- clear_req  in  1  single-cycle request to emit the FIFO-reset code and flush.
- verinject__injector_state  out  32  registered injector command bus.
- cycle_count  out  32  run-cycle counter.
- pending  out  DEPTH_LOG2+1  number of queued commands.
- late_flag  out  1  sticky: a command was issued after its target cycle.
- bad_index_flag  out  1  sticky: a command carried a reserved index.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-low on `reset_n`.
- Reset values:
  - verinject__injector_state = 0xFFFF_FFFF.
  - cycle_count = 0, pending = 0.
  - Both sticky flags = 0.
  - FIFO pointers = 0.
  - FSM = IDLE.
- Counter: cycle_count increments by 1 on every edge with run=1. It wraps 0xFFFF_FFFF→0. It is not affected by clear_req.
- cmd_ready = !full && !clear_req.
- Reserved indices: a command with cmd_index ≥ 0xFFFF_FFFE is accepted (handshake completes) but not enqueued, and sets bad_index_flag.
- FIFO: circular buffer, DEPTH entries, write and read pointers of DEPTH_LOG2+1 bits.
  - pending = wptr − rptr.
  - Full is pending == DEPTH.
- FSM states:
  - IDLE: bus = 0xFFFF_FFFF.
    - If clear_req → CLEAR.
    - Else if run && pending>0 && cycle_count ≥ head.cycle (unsigned) → INJECT.
  - INJECT (one cycle):
    - bus = head.index.
    - Head is popped on the edge leaving this state.
    - Set late_flag if the head target was < cycle_count at the deciding edge.
    - Next state is IDLE, or CLEAR if clear_req is high.
  - CLEAR (one cycle):
    - bus = 0xFFFF_FFFE.
    - rptr ← wptr (flush).
    - late_flag and bad_index_flag ← 0.
    - Next state is IDLE.
- Latency: the bus shows the index in the cycle immediately after the edge at which the due condition was sampled. With run held high, a command with target T appears while cycle_count == T+1.
- Back-to-back: consecutive due commands inject on alternate cycles, with one idle cycle (0xFFFF_FFFF) between them. This guarantees each code is a single-cycle pulse.
- Simultaneous push and pop: both occur; pending is unchanged.
- Push while full: not possible, since cmd_ready=0.
- clear_req has priority over a due injection sampled in the same cycle. That injection is flushed, not issued.
- run=0 freezes cycle_count and suppresses new INJECT transitions. An INJECT already in progress completes.
- reset_n asserted mid-operation: all state returns immediately to reset values. The bus goes to 0xFFFF_FFFF asynchronously.

Optional Feature:
- Macro: VERINJECT_SCHED_BURST_EN.
- When defined:
  - Adds input port cmd_burst [7:0], stored per entry.
  - INJECT repeats cmd_burst+1 times, driving index, index+1, … on consecutive alternate cycles (IDLE cycle between pulses).
  - The entry is popped after the final pulse.
  - An index sum that would reach ≥0xFFFF_FFFE terminates the burst early and sets bad_index_flag.
  - clear_req aborts the burst.
- When undefined: no cmd_burst port; each entry produces exactly one pulse.

Test Plan:
- Reset, run=1, push (cycle=5, index=0x40) → bus=0x40 for exactly the one cycle where cycle_count==6; 0xFFFF_FFFF otherwise; pending 1→0.
- Push 4 entries (targets 10,10,10,10) with run=0 → cmd_ready=0 after the 4th, pending=4. Then run=1 → indices issued on alternate cycles starting at cycle_count==1 after due, with an IDLE gap between each.
- Push (cycle=3, index=7) while cycle_count=20 → issued on the next-but-one cycle, late_flag=1.
- Push index 0xFFFF_FFFE → handshake completes, pending stays 0, bad_index_flag=1, bus never shows the value except via a clear.
- Pulse clear_req in the same cycle as a due head with 3 pending → bus=0xFFFF_FFFE for one cycle, pending=0, flags cleared, no injection emitted.
- Assert reset_n=0 mid-INJECT → bus=0xFFFF_FFFF immediately, cycle_count=0, pending=0.

Source files
------------

// File: rtl/verinject_injection_scheduler.sv
// verinject_injection_scheduler: timed FIFO of (cycle, bit index) commands driving the injector state bus.
// Optional per-command bursts are compiled in when VERINJECT_SCHED_BURST_EN is defined.
module verinject_injection_scheduler #(
   parameter int DEPTH      = 4,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [31:0]           cmd_cycle,
   input  logic [31:0]           cmd_index,
`ifdef VERINJECT_SCHED_BURST_EN
   input  logic [7:0]            cmd_burst,
`endif
   input  logic                  run,
   input  logic                  clear_req,
   output logic [31:0]           verinject__injector_state,
   output logic [31:0]           cycle_count,
   output logic [DEPTH_LOG2:0]   pending,
   output logic                  late_flag,
   output logic                  bad_index_flag
);
   typedef enum logic [1:0] {IDLE, INJECT, CLEAR} state_t;
   state_t r_state, w_next;
   logic [31:0] r_cyc_mem [DEPTH];
   logic [31:0] r_idx_mem [DEPTH];
   logic [DEPTH_LOG2:0] r_wptr, r_rptr;
   logic [31:0] r_bus, r_cycle, w_bus_next, w_head_cyc, w_head_idx, w_offs;
   logic r_late, r_bad;
   logic w_reserved, w_push, w_pop, w_due, w_late_set, w_bad_set, w_last, w_early, w_cont;
   assign pending = r_wptr - r_rptr;
   assign cmd_ready = (pending != DEPTH[DEPTH_LOG2:0]) && !clear_req;
   assign w_reserved = cmd_index >= 32'hFFFF_FFFE;
   assign w_push = cmd_valid && cmd_ready && !w_reserved;
   assign w_head_cyc = r_cyc_mem[r_rptr[DEPTH_LOG2-1:0]];
   assign w_head_idx = r_idx_mem[r_rptr[DEPTH_LOG2-1:0]];
   assign w_due = run && (pending != '0) && (r_cycle >= w_head_cyc);
   assign verinject__injector_state = r_bus;
   assign cycle_count = r_cycle;
   assign late_flag = r_late;
   assign bad_index_flag = r_bad;
`ifdef VERINJECT_SCHED_BURST_EN
   logic [7:0] r_burst_mem [DEPTH];
   logic [7:0] r_rep;
   logic r_cont;
   logic [32:0] w_next_sum;
   // the next pulse of a burst must not land on a reserved code
   assign w_next_sum = {1'b0, w_head_idx} + {25'd0, r_rep} + 33'd1;
   assign w_early = (r_rep != r_burst_mem[r_rptr[DEPTH_LOG2-1:0]]) && (w_next_sum >= 33'h0_FFFF_FFFE);
   assign w_last = (r_rep == r_burst_mem[r_rptr[DEPTH_LOG2-1:0]]) || w_early;
   assign w_cont = r_cont;
   assign w_offs = {24'd0, r_rep};
   always_ff @(posedge clock)
      if (w_push) r_burst_mem[r_wptr[DEPTH_LOG2-1:0]] <= cmd_burst;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         r_rep  <= '0;
         r_cont <= 1'b0;
      end else if (r_state == INJECT) begin
         r_rep  <= w_last ? '0 : r_rep + 8'd1;
         r_cont <= !w_last && !clear_req;
      end else if (r_state == CLEAR) begin
         r_rep  <= '0;
         r_cont <= 1'b0;
      end
`else
   assign w_early = 1'b0;
   assign w_last = 1'b1;
   assign w_cont = 1'b0;
   assign w_offs = '0;
`endif
   always_comb begin
      w_next = IDLE;
      w_pop = 1'b0;
      case (r_state)
         IDLE:    w_next = clear_req ? CLEAR : (w_cont || w_due) ? INJECT : IDLE;
         INJECT: begin
            w_pop  = w_last;
            w_next = clear_req ? CLEAR : IDLE;
         end
         default: w_next = IDLE;
      endcase
      w_late_set = (r_state == IDLE) && (w_next == INJECT) && !w_cont && (w_head_cyc < r_cycle);
      w_bad_set = (cmd_valid && cmd_ready && w_reserved) || ((r_state == INJECT) && w_early);
      w_bus_next = (w_next == INJECT) ? w_head_idx + w_offs : (w_next == CLEAR) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
   end
   always_ff @(posedge clock)
      if (w_push) begin
         r_cyc_mem[r_wptr[DEPTH_LOG2-1:0]] <= cmd_cycle;
         r_idx_mem[r_wptr[DEPTH_LOG2-1:0]] <= cmd_index;
      end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         r_state <= IDLE;
         r_bus   <= 32'hFFFF_FFFF;
         r_cycle <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_late  <= 1'b0;
         r_bad   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_bus   <= w_bus_next;
         if (run) r_cycle <= r_cycle + 32'd1;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (r_state == CLEAR) r_rptr <= r_wptr;
         else if (w_pop) r_rptr <= r_rptr + 1'b1;
         // a flag raised in the flush cycle itself survives the flush
         r_late  <= (r_late && r_state != CLEAR) || w_late_set;
         r_bad   <= (r_bad && r_state != CLEAR) || w_bad_set;
      end
endmodule

// File: tb/tb_verinject_injection_scheduler.sv
// tb_verinject_injection_scheduler: randomized scoreboard bench for verinject_injection_scheduler.
// A queue-based command model predicts every bus pulse and per-cycle status.
module tb_verinject_injection_scheduler;
   localparam int DEPTH = 4;
   localparam int DL = 2;
   localparam logic [31:0] IDLE_CODE = 32'hFFFF_FFFF;
   localparam logic [31:0] CLR_CODE  = 32'hFFFF_FFFE;
   logic clk = 1'b0, reset_n = 1'b1, cmd_valid = 1'b0, run = 1'b0, clear_req = 1'b0;
   logic [31:0] cmd_cycle = '0, cmd_index = '0;
   logic cmd_ready, late_flag, bad_index_flag;
   logic [31:0] bus, cycle_count;
   logic [DL:0] pending;
   int checks = 0, failures = 0;
   bit mon_en = 1'b0;
   typedef struct packed {logic [31:0] cyc; logic [31:0] idx;} cmd_t;
   typedef struct packed {logic [31:0] code; logic [31:0] cyc;} pulse_t;
   typedef struct packed {logic [31:0] cyc; logic [DL:0] pend; logic late; logic bad; logic pulse;} stat_t;
   cmd_t   m_q[$];
   pulse_t q_pulse[$];
   stat_t  q_stat[$];
   logic [31:0] m_cnt = '0;
   int m_ph = 0;
   logic m_late = 1'b0, m_bad = 1'b0;

   verinject_injection_scheduler #(.DEPTH(DEPTH), .DEPTH_LOG2(DL)) dut (
      .clock(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_cycle(cmd_cycle), .cmd_index(cmd_index), .run(run), .clear_req(clear_req),
      .verinject__injector_state(bus), .cycle_count(cycle_count), .pending(pending),
      .late_flag(late_flag), .bad_index_flag(bad_index_flag));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic m_ready();
      return (m_q.size() < DEPTH) && !clear_req;
   endfunction

   // phases: 0 idle, 1 issuing head, 2 flushing
   task automatic model_edge();
      int nph;
      logic rdy;
      cmd_t head;
      rdy = m_ready();
      nph = 0;
      head = '0;
      if (m_ph == 1) begin
         void'(m_q.pop_front());
         nph = clear_req ? 2 : 0;
      end else if (m_ph == 2) begin
         m_q.delete();
         m_late = 1'b0;
         m_bad = 1'b0;
      end else if (clear_req) nph = 2;
      else if (run && m_q.size() > 0 && m_cnt >= m_q[0].cyc) begin
         nph = 1;
         head = m_q[0];
         if (head.cyc < m_cnt) m_late = 1'b1;
      end
      if (cmd_valid && rdy) begin
         if (cmd_index >= CLR_CODE) m_bad = 1'b1;
         else m_q.push_back('{cmd_cycle, cmd_index});
      end
      if (run) m_cnt = m_cnt + 32'd1;
      if (nph == 1) q_pulse.push_back('{head.idx, m_cnt});
      if (nph == 2) q_pulse.push_back('{CLR_CODE, m_cnt});
      m_ph = nph;
      q_stat.push_back('{m_cnt, (DL+1)'(m_q.size()), m_late, m_bad, nph != 0});
   endtask

   task automatic step(input logic v, input logic [31:0] c, input logic [31:0] i, input logic r, input logic cl);
      cmd_valid = v; cmd_cycle = c; cmd_index = i; run = r; clear_req = cl;
      #1 chk("cmd_ready", cmd_ready, m_ready());
      @(posedge clk);
      model_edge();
      #2;
   endtask

   task automatic idle(input int n, input logic r);
      for (int k = 0; k < n; k++) step(1'b0, '0, '0, r, 1'b0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_bus", bus, IDLE_CODE);
      chk("rst_cycle", cycle_count, 0);
      chk("rst_pending", pending, 0);
      chk("rst_flags", {late_flag, bad_index_flag}, 0);
      q_stat.delete(); q_pulse.delete(); m_q.delete();
      m_cnt = '0; m_ph = 0; m_late = 1'b0; m_bad = 1'b0;
      cmd_valid = 1'b0; run = 1'b0; clear_req = 1'b0;
      @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   initial begin
      stat_t s;
      pulse_t p;
      forever begin
         @(negedge clk);
         if (mon_en && reset_n) begin
            if (q_stat.size() > 0) begin
               s = q_stat.pop_front();
               chk("cycle_count", cycle_count, s.cyc);
               chk("pending", pending, s.pend);
               chk("late_flag", late_flag, s.late);
               chk("bad_index_flag", bad_index_flag, s.bad);
               chk("pulse_present", bus != IDLE_CODE, s.pulse);
            end
            if (bus != IDLE_CODE) begin
               if (q_pulse.size() == 0) chk("unexpected_pulse", bus, IDLE_CODE);
               else begin
                  p = q_pulse.pop_front();
                  chk("pulse_code", bus, p.code);
                  chk("pulse_cycle", cycle_count, p.cyc);
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] c, i;
      bit hit;
      #3 do_reset();
      mon_en = 1'b1;
      step(1'b1, 32'd5, 32'h40, 1'b1, 1'b0);
      idle(10, 1'b1);
      do_reset();
      for (int k = 0; k < DEPTH; k++) step(1'b1, 32'd3, 32'h100 + k, 1'b0, 1'b0);
      step(1'b1, 32'd3, 32'h1FF, 1'b0, 1'b0);
      idle(16, 1'b1);
      while (m_cnt < 20) idle(1, 1'b1);
      step(1'b1, 32'd3, 32'd7, 1'b1, 1'b0);
      idle(4, 1'b1);
      step(1'b1, 32'd0, CLR_CODE, 1'b1, 1'b0);
      step(1'b1, 32'd0, IDLE_CODE, 1'b1, 1'b0);
      idle(3, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b1, m_cnt, 32'h200 + k, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b1);
      idle(5, 1'b1);
      step(1'b1, m_cnt, 32'h99, 1'b1, 1'b0);
      hit = 1'b0;
      for (int k = 0; k < 10 && !hit; k++) begin
         idle(1, 1'b1);
         hit = bus != IDLE_CODE;
      end
      chk("inject_seen_before_reset", hit, 1'b1);
      do_reset();
      for (int n = 0; n < 2500; n++) begin
         c = m_cnt + $urandom_range(0, 10);
         if ($urandom % 5 == 0) c = m_cnt - $urandom_range(0, 4);
         i = $urandom & 32'h7FFF_FFFF;
         if ($urandom % 20 == 0) i = 32'hFFFF_FFFE | ($urandom % 2);
         else if ($urandom % 30 == 0) i = 32'hFFFF_FFFD;
         step($urandom % 3 == 0, c, i, $urandom % 5 != 0, $urandom % 40 == 0);
      end
      for (int k = 0; k < 200 && (m_q.size() > 0 || m_ph != 0); k++) idle(1, 1'b1);
      idle(3, 1'b1);
      chk("drain_pulses", q_pulse.size(), 0);
      chk("drain_pending", pending, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
